// File: rtl/qam_tx_pkg.sv
// Shared definitions for the QAM-16 transmit sequencer: state encoding and
// symbol/sample rate arithmetic.
package qam_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int BITS_PER_SYM = 4;

   function automatic int calc_sps(input int div_bit, input int div_samp);
      return (BITS_PER_SYM * div_bit) / div_samp;
   endfunction

   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with enable, synchronous clear and a wrap flag.
// o_next exposes the value the counter takes on the next edge.
module mod_counter #(
   parameter int MOD = 4,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_next,
   output logic         o_wrap
);

   logic [W-1:0] r_count;

   always_comb begin
      o_wrap = i_en && (r_count == W'(MOD - 1));
      if (i_clr || o_wrap)
         o_next = '0;
      else if (i_en)
         o_next = r_count + W'(1);
      else
         o_next = r_count;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else
         r_count <= o_next;
   end

endmodule

// File: rtl/qam_tx_sequencer.sv
// Frame scheduler for the QAM-16 transmit chain: produces bit/sample clock
// enables, zero-pad and carrier selects for one frame, then flushes the filter.
module qam_tx_sequencer
   import qam_tx_pkg::*;
#(
   parameter int DIV_BIT       = 12,
   parameter int DIV_SAMP      = 3,
   parameter int WID_COUNT     = 4,
   parameter int N_SYM_W       = 8,
   parameter int FLUSH_SAMPLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [N_SYM_W-1:0]   frame_len,
   output logic                 busy,
   output logic                 done,
   output logic                 ce_bit,
   output logic                 ce_samp,
   output logic                 sel_zero_pad,
   output logic [WID_COUNT-1:0] sel_carrier,
   output logic                 ce_shift,
   output logic [N_SYM_W-1:0]   sym_cnt
);

   localparam int SPS  = calc_sps(DIV_BIT, DIV_SAMP);
   localparam int W_BD = cnt_width(DIV_BIT);
   localparam int W_BI = cnt_width(BITS_PER_SYM);
   localparam int W_SD = cnt_width(DIV_SAMP);
   localparam int W_SI = cnt_width(SPS);
   localparam int W_FL = cnt_width(FLUSH_SAMPLES);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N_SYM_W-1:0]   r_len;
   logic [N_SYM_W-1:0]   r_sym_cnt;
   logic [WID_COUNT-1:0] r_carrier;
   logic                 r_busy, r_done, r_ce_bit, r_ce_samp, r_zero_pad;

   logic                 w_run, w_flush, w_active, w_kill, w_last_sym, w_nxt_active;
   logic                 w_bit_clr, w_samp_clr, w_flush_clr;
   logic [W_BD-1:0]      w_bit_div_nxt;
   logic [W_BI-1:0]      w_bit_idx_nxt;
   logic [W_SD-1:0]      w_samp_div_nxt;
   logic [W_SI-1:0]      w_samp_idx_nxt;
   logic [W_FL-1:0]      w_flush_nxt;
   logic                 w_bit_div_wrap, w_bit_idx_wrap, w_samp_div_wrap, w_samp_idx_wrap;
   logic                 w_flush_wrap;
   logic                 w_unused;

   assign w_run       = (r_state == ST_RUN);
   assign w_flush     = (r_state == ST_FLUSH);
   assign w_active    = w_run || w_flush;
   assign w_kill      = abort && w_active;
   assign w_bit_clr   = !w_run || w_kill;
   assign w_samp_clr  = !w_active || w_kill;
   assign w_flush_clr = !w_flush || w_kill;
   assign w_last_sym  = (r_sym_cnt == (r_len - N_SYM_W'(1)));
   assign w_unused    = ^{w_bit_idx_nxt, w_flush_nxt, w_samp_idx_wrap};

   mod_counter #(.MOD(DIV_BIT), .W(W_BD)) u_bit_div (
      .clk(clk), .rst(rst), .i_clr(w_bit_clr), .i_en(w_run),
      .o_next(w_bit_div_nxt), .o_wrap(w_bit_div_wrap));

   mod_counter #(.MOD(BITS_PER_SYM), .W(W_BI)) u_bit_idx (
      .clk(clk), .rst(rst), .i_clr(w_bit_clr), .i_en(w_bit_div_wrap),
      .o_next(w_bit_idx_nxt), .o_wrap(w_bit_idx_wrap));

   // Sample phase runs across RUN and FLUSH without a restart.
   mod_counter #(.MOD(DIV_SAMP), .W(W_SD)) u_samp_div (
      .clk(clk), .rst(rst), .i_clr(w_samp_clr), .i_en(w_active),
      .o_next(w_samp_div_nxt), .o_wrap(w_samp_div_wrap));

   mod_counter #(.MOD(SPS), .W(W_SI)) u_samp_idx (
      .clk(clk), .rst(rst), .i_clr(w_samp_clr), .i_en(w_samp_div_wrap),
      .o_next(w_samp_idx_nxt), .o_wrap(w_samp_idx_wrap));

   mod_counter #(.MOD(FLUSH_SAMPLES), .W(W_FL)) u_flush (
      .clk(clk), .rst(rst), .i_clr(w_flush_clr), .i_en(w_flush && w_samp_div_wrap),
      .o_next(w_flush_nxt), .o_wrap(w_flush_wrap));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:
            if (start)
               w_state_nxt = (frame_len != '0) ? ST_RUN : ST_DONE;
         ST_RUN:
            if (abort)
               w_state_nxt = ST_IDLE;
            else if (w_bit_idx_wrap && w_last_sym)
               w_state_nxt = ST_FLUSH;
         ST_FLUSH:
            if (abort)
               w_state_nxt = ST_IDLE;
            else if (w_flush_wrap)
               w_state_nxt = ST_DONE;
         ST_DONE:
            if (r_done)
               w_state_nxt = ST_IDLE;
         default:
            w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_nxt_active = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FLUSH);

   // Outputs are registered from next-state and next-count values so they
   // line up with the counter phase of the cycle they are observed in.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ce_bit   <= 1'b0;
         r_ce_samp  <= 1'b0;
         r_zero_pad <= 1'b0;
         r_sym_cnt  <= '0;
         r_carrier  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= (w_state_nxt == ST_DONE) &&
                       (w_flush || ((r_state == ST_DONE) && !r_done));
         r_ce_bit   <= (w_state_nxt == ST_RUN) && (w_bit_div_nxt == '0);
         r_ce_samp  <= w_nxt_active && (w_samp_div_nxt == '0);
         r_zero_pad <= (w_state_nxt == ST_RUN) && (w_samp_idx_nxt == '0);
         if (!w_nxt_active)
            r_sym_cnt <= '0;
         else if (w_run && w_bit_idx_wrap && (w_state_nxt == ST_RUN))
            r_sym_cnt <= r_sym_cnt + N_SYM_W'(1);
         if (!w_nxt_active)
            r_carrier <= '0;
         else if (r_ce_samp)
            r_carrier <= r_carrier + WID_COUNT'(1);
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ST_IDLE) && start)
         r_len <= frame_len;
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign ce_bit       = r_ce_bit;
   assign ce_samp      = r_ce_samp;
   assign ce_shift     = r_ce_samp;
   assign sel_zero_pad = r_zero_pad;
   assign sel_carrier  = r_carrier;
   assign sym_cnt      = r_sym_cnt;

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Directed bench for qam_tx_sequencer: frame timing, zero-length frames,
// abort, ignored restart and mid-frame reset.
module tb_qam_tx_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [7:0] frame_len;
   logic       busy, done, ce_bit, ce_samp, sel_zero_pad, ce_shift;
   logic [3:0] sel_carrier;
   logic [7:0] sym_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int done_cyc;
   bit [255:0] s_busy, s_done, s_bit, s_samp, s_zp, s_shift;
   int s_car [256];
   int s_sym [256];

   qam_tx_sequencer #(
      .DIV_BIT(12), .DIV_SAMP(3), .WID_COUNT(4), .N_SYM_W(8), .FLUSH_SAMPLES(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
      .busy(busy), .done(done), .ce_bit(ce_bit), .ce_samp(ce_samp),
      .sel_zero_pad(sel_zero_pad), .sel_carrier(sel_carrier), .ce_shift(ce_shift),
      .sym_cnt(sym_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 256) begin
         s_busy[cyc]  = busy;
         s_done[cyc]  = done;
         s_bit[cyc]   = ce_bit;
         s_samp[cyc]  = ce_samp;
         s_zp[cyc]    = sel_zero_pad;
         s_shift[cyc] = ce_shift;
         s_car[cyc]   = int'(sel_carrier);
         s_sym[cyc]   = int'(sym_cnt);
      end
      if (done) done_cyc = cyc;
   endtask

   task automatic clear_log();
      cyc = 0;
      done_cyc = -1;
      s_busy = '0; s_done = '0; s_bit = '0; s_samp = '0; s_zp = '0; s_shift = '0;
      for (int i = 0; i < 256; i++) begin
         s_car[i] = -1;
         s_sym[i] = -1;
      end
   endtask

   task automatic kick(input logic [7:0] len);
      frame_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   function automatic logic [19:0] all_outs();
      return {busy, done, ce_bit, ce_samp, sel_zero_pad, ce_shift, sel_carrier, sym_cnt};
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = 8'd0;
      clear_log();
      repeat (3) tick();
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b0;
      tick();
      chk("idle_outputs", all_outs(), 0);

      // frame_len = 1
      clear_log();
      kick(8'd1);
      run_to(100);
      chk("f1_busy_count", $countones(s_busy), 97);
      chk("f1_busy_first", s_busy[1], 1);
      chk("f1_busy_97_98", {s_busy[98], s_busy[97]}, 2'b01);
      chk("f1_ce_bit_count", $countones(s_bit), 4);
      chk("f1_ce_bit_cycles", {s_bit[37], s_bit[25], s_bit[13], s_bit[1]}, 4'hF);
      chk("f1_ce_samp_count", $countones(s_samp), 32);
      chk("f1_ce_shift_count", $countones(s_shift), 32);
      chk("f1_zero_pad_count", $countones(s_zp), 3);
      chk("f1_zero_pad_cycles", s_zp[3:1], 3'b111);
      chk("f1_done_count", $countones(s_done), 1);
      chk("f1_done_cycle", done_cyc, 97);
      chk("f1_carrier_start", s_car[1], 0);
      chk("f1_carrier_step", s_car[2], 1);

      // frame_len = 3
      clear_log();
      kick(8'd3);
      run_to(200);
      chk("f3_ce_bit_count", $countones(s_bit), 12);
      chk("f3_last_ce_bit", s_bit[133], 1);
      chk("f3_sym_48", s_sym[48], 0);
      chk("f3_sym_49", s_sym[49], 1);
      chk("f3_sym_96", s_sym[96], 1);
      chk("f3_sym_97", s_sym[97], 2);
      chk("f3_sym_144", s_sym[144], 2);
      chk("f3_zp_sym2", s_zp[99:97], 3'b111);
      chk("f3_flush_samp", s_samp[145], 1);
      chk("f3_flush_no_zp", s_zp[145], 0);
      chk("f3_flush_no_bit", $countones(s_bit[192:134]), 0);
      chk("f3_done_cycle", done_cyc, 193);
      chk("f3_car_46", s_car[46], 15);
      chk("f3_car_47", s_car[47], 0);
      chk("f3_car_94", s_car[94], 15);
      chk("f3_car_95", s_car[95], 0);
      chk("f3_samp_count", $countones(s_samp), 64);

      // zero-length frame
      clear_log();
      kick(8'd0);
      run_to(6);
      chk("z_done_cycle", done_cyc, 2);
      chk("z_done_count", $countones(s_done), 1);
      chk("z_busy", s_busy[6:1], 6'b000011);
      chk("z_no_enables", $countones(s_bit) + $countones(s_samp), 0);

      // abort at cycle 30 of a two-symbol frame, restart at 40
      clear_log();
      kick(8'd2);
      run_to(30);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_outs_31", all_outs(), 0);
      run_to(40);
      chk("ab_quiet_busy", s_busy[40:31], 0);
      chk("ab_quiet_en", {s_bit[40:31], s_samp[40:31], s_zp[40:31]}, 0);
      kick(8'd1);
      chk("ab_restart_en", {busy, ce_bit, ce_samp, sel_zero_pad}, 4'hF);
      chk("ab_restart_car", s_car[41], 0);
      run_to(140);
      chk("ab_car_42", s_car[42], 1);
      chk("ab_done_count", $countones(s_done), 1);
      chk("ab_done_cycle", done_cyc, 137);

      // second start while busy is ignored
      clear_log();
      kick(8'd1);
      run_to(10);
      kick(8'd5);
      run_to(100);
      chk("ig_done_cycle", done_cyc, 97);
      chk("ig_ce_bit_count", $countones(s_bit), 4);
      chk("ig_ce_samp_count", $countones(s_samp), 32);

      // reset in the middle of a frame
      clear_log();
      kick(8'd2);
      run_to(60);
      chk("rs_sym_60", s_sym[60], 1);
      rst = 1'b1;
      tick();
      chk("rs_outs_61", all_outs(), 0);
      rst = 1'b0;
      run_to(65);
      chk("rs_idle_busy", s_busy[65:61], 0);
      clear_log();
      kick(8'd1);
      run_to(100);
      chk("rs_next_done", done_cyc, 97);
      chk("rs_next_bits", $countones(s_bit), 4);
      chk("rs_next_car", s_car[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
